// File: rtl/fifo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fifo_pkg                                           |
// | Description : Shared constants for param_fifo: default geometry  |
// |               and the control FSM state encoding.                |
// | Ports       : none (package)                                     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 3;

  // Control FSM: each state names the operation performed on the last edge.
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_INIT     = 3'd0;
  localparam logic [STATE_W-1:0] ST_NO_OP    = 3'd1;
  localparam logic [STATE_W-1:0] ST_WRITE    = 3'd2;
  localparam logic [STATE_W-1:0] ST_WR_ERROR = 3'd3;
  localparam logic [STATE_W-1:0] ST_READ     = 3'd4;
  localparam logic [STATE_W-1:0] ST_RD_ERROR = 3'd5;
  localparam logic [STATE_W-1:0] ST_RD_WR    = 3'd6;

endpackage
`default_nettype wire

// File: rtl/fifo_read_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fifo_read_mux                                      |
// | Description : DEPTH-to-1 word selector for the FIFO read port.   |
// | Ports       : words - all storage words, word i at bits          |
// |                       [i*DATA_WIDTH +: DATA_WIDTH]               |
// |               sel   - index of the word to present               |
// |               data  - selected word (combinational)              |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module fifo_read_mux
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] words,
  input  logic [ADDR_WIDTH-1:0]                 sel,
  output logic [DATA_WIDTH-1:0]                 data
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] word_arr [DEPTH];

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_unpack
      assign word_arr[i] = words[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign data = word_arr[sel];

endmodule
`default_nettype wire

// File: rtl/param_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : param_fifo                                         |
// | Description : Synchronous FIFO, DEPTH = 2**ADDR_WIDTH words, with|
// |               registered read data and per-side ack/err pulses.  |
// | Ports       : clk, reset (sync, active-high)                     |
// |               wr_en, din        - write request / data           |
// |               rd_en, dout       - read request / registered data |
// |               full, empty       - occupancy decodes              |
// |               wr_ack, wr_err    - last cycle's write outcome     |
// |               rd_ack, rd_err    - last cycle's read outcome      |
// |               data_count        - occupancy 0..DEPTH             |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic [ADDR_WIDTH:0]   data_count
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = 1;
  localparam logic [ADDR_WIDTH:0]   COUNT_ZERO = '0;
  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH*DATA_WIDTH-1:0] mem_flat;
  logic [DATA_WIDTH-1:0]       rd_word;
  logic [ADDR_WIDTH-1:0]       wr_ptr;
  logic [ADDR_WIDTH-1:0]       rd_ptr;
  logic                        wr_ok;
  logic                        rd_ok;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  // Set when a WRITE/READ state also carries the opposite side's error
  // (both requested while empty, or both requested while full).
  logic               side_err;
  logic               side_err_next;

  assign full  = (data_count == COUNT_FULL);
  assign empty = (data_count == COUNT_ZERO);

  // A write at full is rejected even when a read is accepted alongside it.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // ---------------- storage and read path ----------------
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_flatten
      assign mem_flat[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
    end
  endgenerate

  fifo_read_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_mux (
    .words (mem_flat),
    .sel   (rd_ptr),
    .data  (rd_word)
  );

  // ---------------- pointers, occupancy, read register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      dout       <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dout   <= rd_word;
      end
      data_count <= data_count + {{ADDR_WIDTH{1'b0}}, wr_ok}
                               - {{ADDR_WIDTH{1'b0}}, rd_ok};
    end
  end

  // ---------------- control FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_INIT;
      side_err <= 1'b0;
    end else begin
      state    <= state_next;
      side_err <= side_err_next;
    end
  end

  // ---------------- control FSM: next state ----------------
  always_comb begin
    state_next    = ST_NO_OP;
    side_err_next = 1'b0;
    if (wr_en && rd_en) begin
      if (empty) begin
        state_next    = ST_WRITE;
        side_err_next = 1'b1;
      end else if (full) begin
        state_next    = ST_READ;
        side_err_next = 1'b1;
      end else begin
        state_next = ST_RD_WR;
      end
    end else if (wr_en) begin
      state_next = full ? ST_WR_ERROR : ST_WRITE;
    end else if (rd_en) begin
      state_next = empty ? ST_RD_ERROR : ST_READ;
    end
  end

  // ---------------- control FSM: outputs ----------------
  always_comb begin
    wr_ack = 1'b0;
    wr_err = 1'b0;
    rd_ack = 1'b0;
    rd_err = 1'b0;
    case (state)
      ST_WRITE: begin
        wr_ack = 1'b1;
        rd_err = side_err;
      end
      ST_WR_ERROR: wr_err = 1'b1;
      ST_READ: begin
        rd_ack = 1'b1;
        wr_err = side_err;
      end
      ST_RD_ERROR: rd_err = 1'b1;
      ST_RD_WR: begin
        wr_ack = 1'b1;
        rd_ack = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_param_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_param_fifo                                      |
// | Description : Self-checking bench for param_fifo: queue-based    |
// |               reference model compared every cycle, plus        |
// |               hand-computed literal expectations.               |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_param_fifo;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [AW:0]   data_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  param_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .din        (din),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .data_count (data_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_dout = '0;
  logic          m_wr_ack = 1'b0, m_wr_err = 1'b0, m_rd_ack = 1'b0, m_rd_err = 1'b0;

  always @(posedge clk) begin
    bit wa, ra;
    if (reset) begin
      q.delete();
      m_dout   = '0;
      m_wr_ack = 1'b0;
      m_wr_err = 1'b0;
      m_rd_ack = 1'b0;
      m_rd_err = 1'b0;
    end else begin
      wa = wr_en && (q.size() < DEPTH);
      ra = rd_en && (q.size() > 0);
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(din);
      m_wr_ack = wa;
      m_wr_err = wr_en && !wa;
      m_rd_ack = ra;
      m_rd_err = rd_en && !ra;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.data_count", DW'(data_count), DW'(q.size()));
      chk("model.full",       DW'(full),       DW'(q.size() == DEPTH));
      chk("model.empty",      DW'(empty),      DW'(q.size() == 0));
      chk("model.dout",       dout,            m_dout);
      chk("model.wr_ack",     DW'(wr_ack),     DW'(m_wr_ack));
      chk("model.wr_err",     DW'(wr_err),     DW'(m_wr_err));
      chk("model.rd_ack",     DW'(rd_ack),     DW'(m_rd_ack));
      chk("model.rd_err",     DW'(rd_err),     DW'(m_rd_err));
    end
  end

  // Drive one cycle of requests; returns 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
    wr_en = w;
    rd_en = r;
    din   = d;
    reset = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    step(1'b1, 1'b1, 32'hDEAD, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("reset.data_count", DW'(data_count), 0);
    chk("reset.empty", DW'(empty), 1);
    chk("reset.full", DW'(full), 0);
    chk("reset.dout", dout, 0);
    chk("reset.flags", DW'({wr_ack, wr_err, rd_ack, rd_err}), 0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk_en = 1'b1;

    // Fill: 0x11..0x88
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, DW'(32'h11 * i), 1'b0);
      chk("fill.data_count", DW'(data_count), DW'(i));
      chk("fill.wr_ack", DW'(wr_ack), 1);
    end
    chk("fill.full", DW'(full), 1);

    // Write when full
    step(1'b1, 1'b0, 32'hFF, 1'b0);
    chk("overflow.wr_err", DW'(wr_err), 1);
    chk("overflow.data_count", DW'(data_count), 8);

    // Drain
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      chk("drain.dout", dout, DW'(32'h11 * i));
      chk("drain.rd_ack", DW'(rd_ack), 1);
    end
    chk("drain.empty", DW'(empty), 1);

    // Read when empty
    step(1'b0, 1'b1, '0, 1'b0);
    chk("underflow.rd_err", DW'(rd_err), 1);
    chk("underflow.dout_hold", dout, 32'h88);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("idle.rd_err_pulse", DW'(rd_err), 0);

    // Pointer wrap
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, DW'(i), 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      chk("wrap.pre_dout", dout, DW'(i));
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'(32'hA0 + i), 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      chk("wrap.dout", dout, DW'(32'hA0 + i));
    end

    // Simultaneous requests at count 0
    step(1'b1, 1'b1, 32'hB0, 1'b0);
    chk("both0.data_count", DW'(data_count), 1);
    chk("both0.rd_err", DW'(rd_err), 1);
    chk("both0.wr_ack", DW'(wr_ack), 1);
    chk("both0.dout_hold", dout, 32'hA5);
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, DW'(32'hB0 + i), 1'b0);

    // Simultaneous requests at count 4
    step(1'b1, 1'b1, 32'hC0, 1'b0);
    chk("both4.data_count", DW'(data_count), 4);
    chk("both4.acks", DW'({wr_ack, rd_ack, wr_err, rd_err}), DW'(4'b1100));
    chk("both4.dout", dout, 32'hB0);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, DW'(32'hC0 + i), 1'b0);

    // Simultaneous requests at count 8
    step(1'b1, 1'b1, 32'hD0, 1'b0);
    chk("both8.data_count", DW'(data_count), 7);
    chk("both8.wr_err", DW'(wr_err), 1);
    chk("both8.rd_ack", DW'(rd_ack), 1);
    chk("both8.dout", dout, 32'hB1);

    // Drain to 3 entries, then reset with both requests pending
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, 1'b0);
    chk("pre_reset.data_count", DW'(data_count), 3);
    step(1'b1, 1'b1, 32'hEE, 1'b1);
    chk("midreset.data_count", DW'(data_count), 0);
    chk("midreset.empty", DW'(empty), 1);
    chk("midreset.dout", dout, 0);
    chk("midreset.flags", DW'({wr_ack, wr_err, rd_ack, rd_err}), 0);
    step(1'b0, 1'b1, '0, 1'b0);
    chk("post_reset.rd_err", DW'(rd_err), 1);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
